// File: rtl/adventure_game_pkg.sv
// Shared encodings for the adventure grid game: move directions, FSM states
// and the row/column to room-index helper.
package adventure_game_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'b00,
        DIR_E = 2'b01,
        DIR_S = 2'b10,
        DIR_W = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_WIN  = 2'b10,
        ST_LOSE = 2'b11
    } state_t;

    function automatic int room_index(input int row, input int col, input int grid_w);
        return row * grid_w + col;
    endfunction

endpackage

// File: rtl/adventure_game_items.sv
// Held-item mask: an item is picked up on the edge the player's room becomes
// that item's room, and only a new game or reset clears the mask.
module adventure_game_items
    import adventure_game_pkg::*;
#(
    parameter int                     NUM_ITEMS  = 2,
    parameter logic [8*NUM_ITEMS-1:0] ITEM_ROOMS = {8'd12, 8'd3},
    parameter int                     RW         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 load,
    input  logic [RW-1:0]        target,
    output logic [NUM_ITEMS-1:0] items
);

    logic [NUM_ITEMS-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            hit[i] = (ITEM_ROOMS[8*i +: 8] == 8'(target));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            items <= '0;
        end else if (clear) begin
            items <= '0;
        end else if (load) begin
            items <= items | hit;
        end
    end

endmodule

// File: rtl/adventure_game_grid.sv
// Grid adventure game: walk a GRID_W x GRID_H map, collect items, slay the
// dragon and reach the exit. Optional move budget: ADVENTURE_MOVE_LIMIT_EN.
module adventure_game_grid
    import adventure_game_pkg::*;
#(
    parameter int                     GRID_W      = 4,
    parameter int                     GRID_H      = 4,
    parameter int                     NUM_ITEMS   = 2,
    parameter logic [8*NUM_ITEMS-1:0] ITEM_ROOMS  = {8'd12, 8'd3},
    parameter int                     START_ROOM  = 0,
    parameter int                     DRAGON_ROOM = 10,
    parameter int                     EXIT_ROOM   = 15,
    parameter int                     MAX_MOVES   = 20,
    localparam int                    RW          = $clog2(GRID_W * GRID_H)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 move,
    input  logic [1:0]           direction,
    output logic [RW-1:0]        room,
    output logic [NUM_ITEMS-1:0] items,
    output logic                 dragon_dead,
    output logic                 blocked,
    output logic                 done,
    output logic                 result
);

    state_t        state, state_next;
    logic [RW-1:0] target;
    logic          off_grid, enter_exit, enter_dragon, all_items;
    logic          reject, play_move, accept;
    int            row, col;

    // Target room and move legality for the current direction.
    always_comb begin
        row      = int'(room) / GRID_W;
        col      = int'(room) % GRID_W;
        off_grid = 1'b0;
        target   = room;
        case (direction)
            DIR_N: if (row == 0) off_grid = 1'b1;
                   else target = RW'(room_index(row - 1, col, GRID_W));
            DIR_E: if (col == GRID_W - 1) off_grid = 1'b1;
                   else target = RW'(room_index(row, col + 1, GRID_W));
            DIR_S: if (row == GRID_H - 1) off_grid = 1'b1;
                   else target = RW'(room_index(row + 1, col, GRID_W));
            default: if (col == 0) off_grid = 1'b1;
                     else target = RW'(room_index(row, col - 1, GRID_W));
        endcase
    end

    assign enter_exit   = (target == RW'(EXIT_ROOM));
    assign enter_dragon = (target == RW'(DRAGON_ROOM));
    assign all_items    = &items;
    assign reject       = off_grid | (enter_exit & ~dragon_dead);
    assign play_move    = (state == ST_PLAY) & move & ~start;
    assign accept       = play_move & ~reject;

`ifdef ADVENTURE_MOVE_LIMIT_EN
    localparam int CW = $clog2(MAX_MOVES + 1);
    logic [CW-1:0] move_cnt;
    logic          budget_spent;

    assign budget_spent = (move_cnt == CW'(MAX_MOVES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_cnt <= '0;
        end else if (start) begin
            move_cnt <= '0;
        end else if (accept) begin
            move_cnt <= move_cnt + 1'b1;
        end
    end
`else
    logic [31:0] unused_max_moves;
    assign unused_max_moves = 32'(MAX_MOVES);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = (state == ST_WIN) || (state == ST_LOSE);
        result     = (state == ST_WIN);
        if (start) begin
            state_next = ST_PLAY;
        end else if (accept) begin
            // The exit wins outright, even on the last budgeted move.
            if (enter_exit) begin
                state_next = ST_WIN;
            end else if (enter_dragon && !all_items) begin
                state_next = ST_LOSE;
            end
`ifdef ADVENTURE_MOVE_LIMIT_EN
            else if (budget_spent) begin
                state_next = ST_LOSE;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            room        <= RW'(START_ROOM);
            dragon_dead <= 1'b0;
            blocked     <= 1'b0;
        end else begin
            blocked <= play_move & reject;
            if (start) begin
                room        <= RW'(START_ROOM);
                dragon_dead <= 1'b0;
            end else if (accept) begin
                room <= target;
                if (enter_dragon && all_items) begin
                    dragon_dead <= 1'b1;
                end
            end
        end
    end

    adventure_game_items #(
        .NUM_ITEMS (NUM_ITEMS),
        .ITEM_ROOMS(ITEM_ROOMS),
        .RW        (RW)
    ) u_items (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .load  (accept),
        .target(target),
        .items (items)
    );

endmodule

// File: tb/tb_adventure_game_grid.sv
// Directed self-checking bench for adventure_game_grid on the default 4x4 map
// (items in rooms 3 and 12, dragon 10, exit 15).
module tb_adventure_game_grid;

`ifdef ADVENTURE_MOVE_LIMIT_EN
    localparam int LIMIT = 3;
`else
    localparam int LIMIT = 20;
`endif

    localparam logic [1:0] N = 2'b00, E = 2'b01, S = 2'b10, W = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       move = 1'b0;
    logic [1:0] direction = 2'b00;
    logic [3:0] room;
    logic [1:0] items;
    logic       dragon_dead, blocked, done, result;

    int n_checks = 0;
    int n_errors = 0;

    adventure_game_grid #(.MAX_MOVES(LIMIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .move       (move),
        .direction  (direction),
        .room       (room),
        .items      (items),
        .dragon_dead(dragon_dead),
        .blocked    (blocked),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_move(input logic [1:0] d);
        @(negedge clk);
        move      = 1'b1;
        direction = d;
        @(negedge clk);
        move      = 1'b0;
    endtask

    task automatic new_game();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_room", room, 0);
        chk("rst_items", items, 0);
        chk("rst_dragon", dragon_dead, 0);
        chk("rst_blocked", blocked, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        @(negedge clk);
        reset = 1'b1;

        // Idle ignores moves
        do_move(E);
        chk("idle_room", room, 0);
        chk("idle_blocked", blocked, 0);

`ifdef ADVENTURE_MOVE_LIMIT_EN
        new_game();
        do_move(E);
        do_move(E);
        chk("lim_two_done", done, 0);
        do_move(N);
        chk("lim_rej_blocked", blocked, 1);
        chk("lim_rej_done", done, 0);
        do_move(E);
        chk("lim_third_done", done, 1);
        chk("lim_third_result", result, 0);
        chk("lim_third_room", room, 3);
`else
        // Off-grid north from room 0
        new_game();
        chk("start_done", done, 0);
        do_move(N);
        chk("n_blocked", blocked, 1);
        chk("n_room", room, 0);
        @(negedge clk);
        chk("n_blocked_pulse", blocked, 0);
        do_move(W);
        chk("w_blocked", blocked, 1);

        // E,E,E picks up item 0 in room 3
        do_move(E);
        chk("e1_room", room, 1);
        do_move(E);
        chk("e2_room", room, 2);
        chk("e2_items", items, 0);
        do_move(E);
        chk("e3_room", room, 3);
        chk("e3_items", items, 1);
        do_move(E);
        chk("e_edge_blocked", blocked, 1);
        chk("e_edge_room", room, 3);

        // Into the dragon without both items
        do_move(S);
        do_move(S);
        chk("s_room", room, 11);
        do_move(W);
        chk("lose_done", done, 1);
        chk("lose_result", result, 0);
        chk("lose_room", room, 10);
        do_move(E);
        chk("frozen_room", room, 10);
        chk("frozen_blocked", blocked, 0);

        // Full win
        new_game();
        chk("restart_done", done, 0);
        chk("restart_items", items, 0);
        do_move(E); do_move(E); do_move(E);
        do_move(W); do_move(W); do_move(W);
        do_move(S); do_move(S); do_move(S);
        chk("win_room12", room, 12);
        chk("win_items", items, 3);
        do_move(E); do_move(E); do_move(N);
        chk("slay_room", room, 10);
        chk("slay_dragon", dragon_dead, 1);
        chk("slay_done", done, 0);
        do_move(E);
        do_move(S);
        chk("win_done", done, 1);
        chk("win_result", result, 1);
        chk("win_room", room, 15);

        // Exit locked while dragon lives; start beats move
        new_game();
        do_move(S); do_move(S); do_move(S);
        do_move(E); do_move(E);
        chk("r14_items", items, 2);
        do_move(E);
        chk("exit_blocked", blocked, 1);
        chk("exit_room", room, 14);
        do_move(S);
        chk("s_edge_blocked", blocked, 1);
        @(negedge clk);
        start = 1'b1; move = 1'b1; direction = W;
        @(negedge clk);
        start = 1'b0; move = 1'b0;
        chk("startmv_room", room, 0);
        chk("startmv_items", items, 0);
        chk("startmv_blocked", blocked, 0);
        chk("startmv_done", done, 0);
`endif

        // Asynchronous reset mid-game, then start on the first edge after release
        new_game();
        do_move(S);
        #2 reset = 1'b0;
        #1;
        chk("async_room", room, 0);
        chk("async_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        do_move(E);
        chk("post_rst_idle_room", room, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_move(S);
        chk("first_edge_start_room", room, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adventure_game_grid.md
ADVENTURE_GAME_GRID -- requirements
Module: adventure_game_grid

Interface
REQ-001 SHALL have parameter GRID_W, default 4, meaning grid columns (2..16).
REQ-002 SHALL have parameter GRID_H, default 4, meaning grid rows (2..16).
REQ-003 SHALL have parameter NUM_ITEMS, default 2, meaning collectable items (1..8).
REQ-004 SHALL have parameter ITEM_ROOMS, default {8'd12, 8'd3}, meaning packed 8-bit room index per item, item 0 in the LSBs.
REQ-005 SHALL have parameters START_ROOM=0, DRAGON_ROOM=10, EXIT_ROOM=15, all room indices.
REQ-006 SHALL have parameter MAX_MOVES, default 20, meaning move budget used only under the macro in REQ-030.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port start, input, 1 bit, new-game request.
REQ-010 SHALL have port move, input, 1 bit, one-cycle move strobe.
REQ-011 SHALL have port direction, input, 2 bits: 00 N (row-1), 01 E (col+1), 10 S (row+1), 11 W (col-1).
REQ-012 SHALL have port room, output, RW = $clog2(GRID_W*GRID_H) bits, current room index = row*GRID_W+col.
REQ-013 SHALL have ports items (output, NUM_ITEMS bits, held-item mask) and dragon_dead (output, 1 bit).
REQ-014 SHALL have ports blocked (output, 1 bit, one-cycle rejected-move pulse), done (output, 1 bit) and result (output, 1 bit, 1 = win, valid while done=1).

Function
REQ-015 SHALL implement FSM IDLE, PLAY, WIN, LOSE; done=1 exactly in WIN or LOSE; result=1 exactly in WIN.
REQ-016 SHALL go from any state to PLAY on start=1, setting room=START_ROOM and clearing items, dragon_dead and the move counter; start takes priority over a simultaneous move.
REQ-017 SHALL ignore move outside PLAY, with no blocked pulse.
REQ-018 SHALL, in PLAY with move=1, compute the target room combinationally and register the outcome on the same edge: room, items, dragon_dead and state are visible on the following cycle (latency 1).
REQ-019 SHALL reject a move leaving the grid (N at row 0, S at row GRID_H-1, W at col 0, E at col GRID_W-1): room unchanged, blocked=1 for one cycle.
REQ-020 SHALL reject a move into EXIT_ROOM while dragon_dead=0, as in REQ-019.
REQ-021 SHALL, on an accepted move into EXIT_ROOM with dragon_dead=1, update room and enter WIN.
REQ-022 SHALL, on an accepted move into DRAGON_ROOM, set dragon_dead=1 if items is all ones, else update room and enter LOSE.
REQ-023 SHALL set items[i] on the edge on which room becomes ITEM_ROOMS[i]; items never clear except by start or reset.
REQ-024 SHALL hold room, items and dragon_dead frozen in WIN and LOSE.
REQ-025 SHALL deassert blocked on every cycle without a rejected move.

Reset
REQ-026 SHALL, while reset=0, asynchronously force state=IDLE, room=START_ROOM, items=0, dragon_dead=0, blocked=0, done=0, result=0 and move counter=0.
REQ-027 SHALL, on reset assertion mid-game, abandon the game with no completion pulse; after release it remains in IDLE until start.
REQ-028 SHALL treat a start coincident with the first edge after reset release as a normal start.

Configuration
REQ-029 SHALL treat ITEM_ROOMS entries equal to START_ROOM as items that are not pre-collected; collection happens only by entering the room.
REQ-030 SHALL, with ADVENTURE_MOVE_LIMIT_EN defined, count accepted moves and enter LOSE on the edge of accepted move number MAX_MOVES unless that move enters WIN (WIN has priority); rejected moves are not counted.
REQ-031 SHALL, without ADVENTURE_MOVE_LIMIT_EN, contain no move counter, with MAX_MOVES unused.

Structure
REQ-032 SHALL place the direction encodings, FSM state encoding and room-index helper function in package adventure_game_pkg.
REQ-033 SHALL implement item collection in sub-module adventure_game_items (target room in, items mask out, clear on start), instantiated once.

Verification
REQ-034 SHALL verify: reset, start, N from room 0 -> blocked=1 for 1 cycle, room=0.
REQ-035 SHALL verify: E,E,E from room 0 -> room=3 and items=2'b01 on the same cycle.
REQ-036 SHALL verify: items=2'b01, path 3->7->11->10 -> done=1, result=0, room=10.
REQ-037 SHALL verify: collect both items (3, then 12), enter 10 -> dragon_dead=1; 11, 15 -> done=1, result=1.
REQ-038 SHALL verify: at room 14 with dragon alive, E -> blocked=1, room=14; start asserted with move=1 -> room=0, items=0.
REQ-039 SHALL verify: ADVENTURE_MOVE_LIMIT_EN with MAX_MOVES=3, three accepted moves from 0 -> LOSE after the third; a rejected move leaves the count unchanged.
